// File: rtl/core_pc_redirect_if.sv
`default_nettype none
// ============================================================================
// Module      : core_pc_redirect_if
// Description : Instruction-memory fetch handshake between the PC unit and
//               instruction memory.
//                 IMEM_REQ  - fetch request (PC unit -> memory)
//                 IMEM_ADDR - fetch address (PC unit -> memory)
//                 IMEM_ACK  - request accepted this cycle (memory -> PC unit)
// Revision    : 1.0 - initial release
// ============================================================================
interface core_pc_redirect_if;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_ACK;

    // PC unit side
    modport master (
        output IMEM_REQ,
        output IMEM_ADDR,
        input  IMEM_ACK
    );

    // Instruction-memory side
    modport slave (
        input  IMEM_REQ,
        input  IMEM_ADDR,
        output IMEM_ACK
    );
endinterface
`default_nettype wire

// File: rtl/core_pc_redirect.sv
`default_nettype none
// ============================================================================
// Module      : core_pc_redirect
// Description : Fetch-side program-counter unit. Issues sequential fetch
//               addresses over a request/accept handshake, redirects to a
//               branch/jump target followed by a fixed-length flush, and
//               traps permanently on a misaligned redirect target.
// Ports       : CLK, NRST          - clock, async active-low reset
//               C_BRANCH, TAKE_BRANCH, BRANCH_TARGET - branch resolution
//               C_JUMP, JUMP_TARGET - unconditional jump resolution
//               STALL              - downstream cannot accept an instruction
//               imem               - fetch handshake (REQ/ADDR out, ACK in)
//               PC, PC_VALID       - last accepted address, 1-cycle update pulse
//               FLUSH              - kill younger pipeline contents
//               MISALIGNED         - sticky misaligned-target trap
// Parameters  : RESET_VECTOR - first fetch address after reset
//               FLUSH_CYCLES - cycles FLUSH is held after a redirect (1..15)
// Revision    : 1.0 - initial release
// ============================================================================
module core_pc_redirect #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  wire logic               CLK,
    input  wire logic               NRST,
    input  wire logic               C_BRANCH,
    input  wire logic               TAKE_BRANCH,
    input  wire logic [31:0]        BRANCH_TARGET,
    input  wire logic               C_JUMP,
    input  wire logic [31:0]        JUMP_TARGET,
    input  wire logic               STALL,
    core_pc_redirect_if.master      imem,
    output logic [31:0]             PC,
    output logic                    PC_VALID,
    output logic                    FLUSH,
    output logic                    MISALIGNED
);

    typedef enum logic [1:0] {
        S_BOOT     = 2'd0,
        S_FETCH    = 2'd1,
        S_FLUSH_ST = 2'd2,
        S_TRAP     = 2'd3
    } state_t;

    localparam logic [3:0] c_flush_init = 4'(FLUSH_CYCLES);

    state_t      r_state;
    logic [31:0] r_imem_addr;
    logic [31:0] r_pc;
    logic        r_pc_valid;
    logic        r_flush;
    logic        r_misaligned;
    logic [3:0]  r_flush_cnt;

    state_t      w_nxt_state;
    logic [31:0] w_nxt_imem_addr;
    logic [31:0] w_nxt_pc;
    logic        w_nxt_pc_valid;
    logic        w_nxt_flush;
    logic        w_nxt_misaligned;
    logic [3:0]  w_nxt_flush_cnt;

    logic        w_branch_taken;
    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_target_misaligned;
    logic        w_req;
    logic        w_accept;

    // The branch belongs to the older instruction, so it wins over a
    // simultaneous jump.
    assign w_branch_taken      = C_BRANCH && TAKE_BRANCH;
    assign w_redirect          = w_branch_taken || C_JUMP;
    assign w_target            = w_branch_taken ? BRANCH_TARGET : JUMP_TARGET;
    assign w_target_misaligned = (w_target[1:0] != 2'b00);

    assign w_req    = (r_state == S_FETCH) && !STALL;
    // A redirect in the same cycle discards the acknowledged fetch: it is on
    // the wrong path.
    assign w_accept = w_req && imem.IMEM_ACK && !w_redirect;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            r_state      <= S_BOOT;
            r_imem_addr  <= RESET_VECTOR;
            r_pc         <= RESET_VECTOR;
            r_pc_valid   <= 1'b0;
            r_flush      <= 1'b0;
            r_misaligned <= 1'b0;
            r_flush_cnt  <= 4'd0;
        end else begin
            r_state      <= w_nxt_state;
            r_imem_addr  <= w_nxt_imem_addr;
            r_pc         <= w_nxt_pc;
            r_pc_valid   <= w_nxt_pc_valid;
            r_flush      <= w_nxt_flush;
            r_misaligned <= w_nxt_misaligned;
            r_flush_cnt  <= w_nxt_flush_cnt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_imem_addr  = r_imem_addr;
        w_nxt_pc         = r_pc;
        w_nxt_pc_valid   = 1'b0;
        w_nxt_flush      = 1'b0;
        w_nxt_misaligned = r_misaligned;
        w_nxt_flush_cnt  = r_flush_cnt;

        case (r_state)
            S_BOOT: begin
                w_nxt_state = S_FETCH;
            end

            S_FETCH, S_FLUSH_ST: begin
                if (w_redirect) begin
                    if (w_target_misaligned) begin
                        // Address and PC freeze at their current values.
                        w_nxt_state      = S_TRAP;
                        w_nxt_misaligned = 1'b1;
                        w_nxt_flush      = 1'b1;
                    end else begin
                        // Also restarts an in-progress flush.
                        w_nxt_state     = S_FLUSH_ST;
                        w_nxt_imem_addr = w_target;
                        w_nxt_flush_cnt = c_flush_init;
                        w_nxt_flush     = 1'b1;
                    end
                end else if (r_state == S_FETCH) begin
                    if (w_accept) begin
                        w_nxt_pc        = r_imem_addr;
                        w_nxt_pc_valid  = 1'b1;
                        w_nxt_imem_addr = r_imem_addr + 32'd4;
                    end
                end else begin
                    // FLUSH was raised on entry, so leaving when the count
                    // reaches 1 keeps it high for exactly FLUSH_CYCLES cycles.
                    if (r_flush_cnt <= 4'd1) begin
                        w_nxt_state = S_FETCH;
                    end else begin
                        w_nxt_flush_cnt = r_flush_cnt - 4'd1;
                        w_nxt_flush     = 1'b1;
                    end
                end
            end

            S_TRAP: begin
                w_nxt_flush = 1'b1;
            end

            default: begin
                w_nxt_state = S_BOOT;
            end
        endcase
    end

    assign imem.IMEM_REQ  = w_req;
    assign imem.IMEM_ADDR = r_imem_addr;
    assign PC             = r_pc;
    assign PC_VALID       = r_pc_valid;
    assign FLUSH          = r_flush;
    assign MISALIGNED     = r_misaligned;

endmodule
`default_nettype wire

// File: tb/tb_core_pc_redirect.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_pc_redirect
// Description : Self-checking bench for core_pc_redirect. A table of
//               directed vectors walks boot, sequential fetch, taken and
//               not-taken branches, branch/jump priority, stall, flush
//               restart, address wrap and the misaligned trap; hand-written
//               sequences cover trap persistence and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_pc_redirect;

    logic        CLK;
    logic        NRST;
    logic        C_BRANCH;
    logic        TAKE_BRANCH;
    logic [31:0] BRANCH_TARGET;
    logic        C_JUMP;
    logic [31:0] JUMP_TARGET;
    logic        STALL;
    logic [31:0] PC;
    logic        PC_VALID;
    logic        FLUSH;
    logic        MISALIGNED;

    core_pc_redirect_if imem ();

    core_pc_redirect #(
        .RESET_VECTOR (32'h0000_0100),
        .FLUSH_CYCLES (2)
    ) dut (
        .CLK           (CLK),
        .NRST          (NRST),
        .C_BRANCH      (C_BRANCH),
        .TAKE_BRANCH   (TAKE_BRANCH),
        .BRANCH_TARGET (BRANCH_TARGET),
        .C_JUMP        (C_JUMP),
        .JUMP_TARGET   (JUMP_TARGET),
        .STALL         (STALL),
        .imem          (imem),
        .PC            (PC),
        .PC_VALID      (PC_VALID),
        .FLUSH         (FLUSH),
        .MISALIGNED    (MISALIGNED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        cb;
        logic        tb;
        logic [31:0] bt;
        logic        cj;
        logic [31:0] jt;
        logic        st;
        logic        ack;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic        e_valid;
        logic        e_flush;
        logic        e_mis;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[$];

    localparam logic [31:0] c_x = 32'h0;

    function automatic vec_t mk(
        input logic cb, input logic tb, input logic [31:0] bt,
        input logic cj, input logic [31:0] jt,
        input logic st, input logic ack,
        input logic e_req, input logic [31:0] e_addr, input logic [31:0] e_pc,
        input logic e_valid, input logic e_flush, input logic e_mis);
        vec_t v;
        v.cb = cb; v.tb = tb; v.bt = bt; v.cj = cj; v.jt = jt;
        v.st = st; v.ack = ack;
        v.e_req = e_req; v.e_addr = e_addr; v.e_pc = e_pc;
        v.e_valid = e_valid; v.e_flush = e_flush; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Entered at a falling edge: drive inputs, check the combinational
    // request, clock once, check the registered outputs, return at the next
    // falling edge.
    task automatic apply(input vec_t v, input string tag);
        C_BRANCH      = v.cb;
        TAKE_BRANCH   = v.tb;
        BRANCH_TARGET = v.bt;
        C_JUMP        = v.cj;
        JUMP_TARGET   = v.jt;
        STALL         = v.st;
        imem.IMEM_ACK = v.ack;
        #1;
        chk({tag, ".req"}, {31'd0, imem.IMEM_REQ}, {31'd0, v.e_req});
        @(posedge CLK);
        #1;
        chk({tag, ".addr"},  imem.IMEM_ADDR,        v.e_addr);
        chk({tag, ".pc"},    PC,                    v.e_pc);
        chk({tag, ".valid"}, {31'd0, PC_VALID},     {31'd0, v.e_valid});
        chk({tag, ".flush"}, {31'd0, FLUSH},        {31'd0, v.e_flush});
        chk({tag, ".mis"},   {31'd0, MISALIGNED},   {31'd0, v.e_mis});
        @(negedge CLK);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".req"},   {31'd0, imem.IMEM_REQ}, 32'd0);
        chk({tag, ".addr"},  imem.IMEM_ADDR,         32'h100);
        chk({tag, ".pc"},    PC,                     32'h100);
        chk({tag, ".valid"}, {31'd0, PC_VALID},      32'd0);
        chk({tag, ".flush"}, {31'd0, FLUSH},         32'd0);
        chk({tag, ".mis"},   {31'd0, MISALIGNED},    32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        NRST = 1'b0;
        C_BRANCH = 1'b0; TAKE_BRANCH = 1'b0; BRANCH_TARGET = '0;
        C_JUMP = 1'b0; JUMP_TARGET = '0; STALL = 1'b0;
        imem.IMEM_ACK = 1'b1;

        //            cb tb bt            cj jt            st ack  req addr          pc            v  f  m
        // boot and sequential fetch
        vecs.push_back(mk(0, 0, c_x,          0, c_x,          0, 1,   0, 32'h100,       32'h100,      0, 0, 0));
        vecs.push_back(mk(0, 0, c_x,          0, c_x,          0, 1,   1, 32'h104,       32'h100,      1, 0, 0));
        vecs.push_back(mk(0, 0, c_x,          0, c_x,          0, 1,   1, 32'h108,       32'h104,      1, 0, 0));
        vecs.push_back(mk(0, 0, c_x,          0, c_x,          0, 1,   1, 32'h10C,       32'h108,      1, 0, 0));
        vecs.push_back(mk(0, 0, c_x,          0, c_x,          0, 0,   1, 32'h10C,       32'h108,      0, 0, 0));
        // jump to 0x20
        vecs.push_back(mk(0, 0, c_x,          1, 32'h20,       0, 1,   1, 32'h20,        32'h108,      0, 1, 0));
        vecs.push_back(mk(0, 0, c_x,          0, c_x,          0, 1,   0, 32'h20,        32'h108,      0, 1, 0));
        vecs.push_back(mk(0, 0, c_x,          0, c_x,          0, 1,   0, 32'h20,        32'h108,      0, 0, 0));
        // taken branch at 0x20 with ack: ack dropped
        vecs.push_back(mk(1, 1, 32'h400,      0, c_x,          0, 1,   1, 32'h400,       32'h108,      0, 1, 0));
        vecs.push_back(mk(0, 0, c_x,          0, c_x,          0, 1,   0, 32'h400,       32'h108,      0, 1, 0));
        vecs.push_back(mk(0, 0, c_x,          0, c_x,          0, 1,   0, 32'h400,       32'h108,      0, 0, 0));
        vecs.push_back(mk(0, 0, c_x,          0, c_x,          0, 1,   1, 32'h404,       32'h400,      1, 0, 0));
        // not-taken branch: sequential
        vecs.push_back(mk(1, 0, 32'h800,      0, c_x,          0, 1,   1, 32'h408,       32'h404,      1, 0, 0));
        // branch and jump together: branch wins
        vecs.push_back(mk(1, 1, 32'h80,       1, 32'h200,      0, 1,   1, 32'h80,        32'h404,      0, 1, 0));
        vecs.push_back(mk(0, 0, c_x,          0, c_x,          0, 1,   0, 32'h80,        32'h404,      0, 1, 0));
        vecs.push_back(mk(0, 0, c_x,          0, c_x,          0, 1,   0, 32'h80,        32'h404,      0, 0, 0));
        vecs.push_back(mk(0, 0, c_x,          0, c_x,          0, 1,   1, 32'h84,        32'h80,       1, 0, 0));
        // jump to 0x40, then stall 3 cycles
        vecs.push_back(mk(0, 0, c_x,          1, 32'h40,       0, 0,   1, 32'h40,        32'h80,       0, 1, 0));
        vecs.push_back(mk(0, 0, c_x,          0, c_x,          0, 0,   0, 32'h40,        32'h80,       0, 1, 0));
        vecs.push_back(mk(0, 0, c_x,          0, c_x,          0, 0,   0, 32'h40,        32'h80,       0, 0, 0));
        vecs.push_back(mk(0, 0, c_x,          0, c_x,          1, 1,   0, 32'h40,        32'h80,       0, 0, 0));
        vecs.push_back(mk(0, 0, c_x,          0, c_x,          1, 1,   0, 32'h40,        32'h80,       0, 0, 0));
        vecs.push_back(mk(0, 0, c_x,          0, c_x,          1, 1,   0, 32'h40,        32'h80,       0, 0, 0));
        vecs.push_back(mk(0, 0, c_x,          0, c_x,          0, 1,   1, 32'h44,        32'h40,       1, 0, 0));
        // redirect to 0x100, re-redirect to 0x300 in first flush cycle
        vecs.push_back(mk(0, 0, c_x,          1, 32'h100,      0, 1,   1, 32'h100,       32'h40,       0, 1, 0));
        vecs.push_back(mk(0, 0, c_x,          1, 32'h300,      0, 1,   0, 32'h300,       32'h40,       0, 1, 0));
        vecs.push_back(mk(0, 0, c_x,          0, c_x,          0, 1,   0, 32'h300,       32'h40,       0, 1, 0));
        vecs.push_back(mk(0, 0, c_x,          0, c_x,          0, 1,   0, 32'h300,       32'h40,       0, 0, 0));
        vecs.push_back(mk(0, 0, c_x,          0, c_x,          0, 1,   1, 32'h304,       32'h300,      1, 0, 0));
        // redirect overrides stall; wrap-around at 0xFFFF_FFFC
        vecs.push_back(mk(0, 0, c_x,          1, 32'hFFFF_FFFC, 1, 1,  0, 32'hFFFF_FFFC, 32'h300,      0, 1, 0));
        vecs.push_back(mk(0, 0, c_x,          0, c_x,          0, 1,   0, 32'hFFFF_FFFC, 32'h300,      0, 1, 0));
        vecs.push_back(mk(0, 0, c_x,          0, c_x,          0, 1,   0, 32'hFFFF_FFFC, 32'h300,      0, 0, 0));
        vecs.push_back(mk(0, 0, c_x,          0, c_x,          0, 1,   1, 32'h0,         32'hFFFF_FFFC, 1, 0, 0));
        vecs.push_back(mk(0, 0, c_x,          0, c_x,          0, 1,   1, 32'h4,         32'h0,        1, 0, 0));
        // misaligned jump: trap, address and PC frozen
        vecs.push_back(mk(0, 0, c_x,          1, 32'h202,      0, 1,   1, 32'h4,         32'h0,        0, 1, 1));

        // reset state
        repeat (2) @(posedge CLK);
        #1;
        chk_reset_state("reset");
        @(negedge CLK);
        NRST = 1'b1;

        foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

        // trap persists; a later aligned redirect is ignored
        for (int k = 0; k < 22; k++) begin
            apply(mk((k == 10), 1, 32'h500, (k == 15), 32'h600, 0, 1,
                     0, 32'h4, 32'h0, 0, 1, 1), $sformatf("trap%0d", k));
        end

        // asynchronous reset clears the trap mid-cycle
        #2 NRST = 1'b0;
        #1 chk_reset_state("rst_trap");
        @(negedge CLK);
        NRST = 1'b1;
        apply(mk(0, 0, c_x, 0, c_x, 0, 1, 0, 32'h100, 32'h100, 0, 0, 0), "boot2_0");
        apply(mk(0, 0, c_x, 0, c_x, 0, 1, 1, 32'h104, 32'h100, 1, 0, 0), "boot2_1");
        apply(mk(0, 0, c_x, 1, 32'h600, 0, 1, 1, 32'h600, 32'h100, 0, 1, 0), "boot2_jmp");

        // reset in the middle of a flush leaves no partial flush behind
        #2 NRST = 1'b0;
        #1 chk_reset_state("rst_flush");
        @(negedge CLK);
        NRST = 1'b1;
        apply(mk(0, 0, c_x, 0, c_x, 0, 1, 0, 32'h100, 32'h100, 0, 0, 0), "boot3_0");
        apply(mk(0, 0, c_x, 0, c_x, 0, 1, 1, 32'h104, 32'h100, 1, 0, 0), "boot3_1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
